// File: rtl/acc_pkg.sv
// Shared constants for the 16-lane adder-tree bus: lane count, count width, lane saturation limits
// and the packer FSM state type. Optional build macro ACC_PACK_ROUND_EN is consumed by acc_lane_narrow.
package acc_pkg;
  localparam int ACC_LANES = 16;
  localparam int ACC_CNT_W = 5;
  localparam int ACC_PREC  = 16;

  localparam logic signed [ACC_PREC-1:0] ACC_SAT_MAX = {1'b0, {(ACC_PREC-1){1'b1}}};
  localparam logic signed [ACC_PREC-1:0] ACC_SAT_MIN = {1'b1, {(ACC_PREC-1){1'b0}}};

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } acc_state_e;
endpackage

// File: rtl/acc_lane_narrow.sv
// Combinational rescale of one signed product to a saturated signed lane.
// ACC_PACK_ROUND_EN defined: round half up before the shift; undefined: floor by arithmetic shift.
module acc_lane_narrow
  import acc_pkg::*;
#(
  parameter int P     = ACC_PREC,
  parameter int IN_W  = 32,
  parameter int SHIFT = 14
) (
  input  logic [IN_W-1:0] din,
  output logic [P-1:0]    lane,
  output logic            sat
);
  // Limits sign-extended to the IN_W+1 working width so compares stay signed.
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-P+2){1'b0}}, {(P-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-P+2){1'b1}}, {(P-1){1'b0}}};
`ifdef ACC_PACK_ROUND_EN
  localparam logic signed [IN_W:0] RND_V = (IN_W+1)'(2 ** (SHIFT-1));
`endif

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] shifted;

  always_comb begin
    ext = {din[IN_W-1], din};
`ifdef ACC_PACK_ROUND_EN
    ext = ext + RND_V;
`endif
    shifted = ext >>> SHIFT;
    lane    = shifted[P-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      lane = MAX_V[P-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      lane = MIN_V[P-1:0];
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/acc_lane_packer.sv
// Packs a stream of signed products into 16-lane adder-tree vectors, zero-padding short groups.
// Build macro ACC_PACK_ROUND_EN selects round-half-up lane conversion (see acc_lane_narrow).
module acc_lane_packer
  import acc_pkg::*;
#(
  parameter int PRECISION_ADDER = 16,
  parameter int IN_W            = 32,
  parameter int SHIFT           = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_W-1:0]                 in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PRECISION_ADDER*16-1:0]   out_data,
  output logic [ACC_CNT_W-1:0]            out_cnt,
  output logic                            out_last,
  output logic                            sat_flag,
  output acc_state_e                      dbg_state
);
  // Handshake: a transfer occurs on any rising edge where valid && ready; payload holds while
  // valid && !ready, and in_ready is a function of state only.
  localparam int BUS_W = PRECISION_ADDER * ACC_LANES;

  acc_state_e           state_q, state_d;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0]     col_q, col_d;
  logic                 col_sat_q, col_sat_d;
  logic                 hold_last_q, hold_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [BUS_W-1:0]     out_data_q, out_data_d;
  logic [ACC_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 out_last_q, out_last_d;
  logic                 sat_q, sat_d;

  logic [PRECISION_ADDER-1:0] lane;
  logic                       lane_sat;
  logic                       slot_free;
  logic                       close;

  acc_lane_narrow #(
    .P     (PRECISION_ADDER),
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_narrow (
    .din  (in_data),
    .lane (lane),
    .sat  (lane_sat)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign close     = (cnt_q == 5'd15) || in_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    col_sat_d   = col_sat_q;
    hold_last_d = hold_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    sat_d       = sat_q;
    in_ready    = (state_q == FILL);

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          col_d[int'(cnt_q[3:0]) * PRECISION_ADDER +: PRECISION_ADDER] = lane;
          col_sat_d = col_sat_q | lane_sat;
          if (close) begin
            if (slot_free) begin
              out_valid_d = 1'b1;
              out_data_d  = col_d;
              out_cnt_d   = cnt_q + 5'd1;
              out_last_d  = in_last;
              sat_d       = col_sat_d;
              col_d       = '0;
              col_sat_d   = 1'b0;
              cnt_d       = '0;
            end else begin
              // Closing lane is already in the collector; cnt keeps its index for out_cnt.
              state_d     = HOLD;
              hold_last_d = in_last;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = col_q;
          out_cnt_d   = cnt_q + 5'd1;
          out_last_d  = hold_last_q;
          sat_d       = col_sat_q;
          col_d       = '0;
          col_sat_d   = 1'b0;
          cnt_d       = '0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      col_q       <= '0;
      col_sat_q   <= 1'b0;
      hold_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      col_sat_q   <= col_sat_d;
      hold_last_q <= hold_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;
  assign dbg_state = state_q;
endmodule
